// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer
//   Walks a word-aligned region of the unified instruction/data memory through
//   the LSU data port with LW-type reads. Each 32-bit word is streamed out on a
//   valid/ready interface to a UART/trace sink. The port must only be driven
//   while the core is held idle.
//
// Build option:
//   DUMP_CHECKSUM_EN - when defined, a 32-bit checksum word (sum of all data
//                      words, modulo 2^32) follows the data and carries
//                      io_out_last. When undefined, io_out_last is on the final
//                      data word.
//
// Parameters:
//   RD_LAT            memory read latency, address to io_mem_lsuData (0..3)
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   io_start          one-cycle dump request (ignored unless idle)
//   io_baseAddr       first byte address (low two bits ignored)
//   io_wordCount      number of data words to dump
//   io_mem_*          memory data port (read-only use: LW, no writes)
//   io_mem_lsuData    read data returned by memory
//   io_out_valid/ready/bits/last   output word stream
//   io_busy           dump in progress
//   io_done           one-cycle completion pulse
module mem_dump_streamer #(
   parameter int unsigned RD_LAT = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_start,
   input  logic [63:0] io_baseAddr,
   input  logic [31:0] io_wordCount,
   output logic [63:0] io_mem_dataAddr,
   output logic        io_mem_writeEn,
   output logic [31:0] io_mem_writeData,
   output logic [2:0]  io_mem_func3,
   input  logic [31:0] io_mem_lsuData,
   output logic        io_out_valid,
   input  logic        io_out_ready,
   output logic [31:0] io_out_bits,
   output logic        io_out_last,
   output logic        io_busy,
   output logic        io_done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_HOLD = 3'd2;
`ifdef DUMP_CHECKSUM_EN
   localparam logic [2:0] S_CSUM = 3'd3;
`endif
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [1:0] LAT_MAX = 2'(RD_LAT);

   logic [2:0]  state;
   logic [31:0] remaining;
   logic [1:0]  lat_cnt;
`ifdef DUMP_CHECKSUM_EN
   logic [31:0] csum;
`endif

   assign io_mem_writeEn   = 1'b0;
   assign io_mem_writeData = '0;
   assign io_mem_func3     = 3'b010;
   assign io_busy          = (state != S_IDLE);

   // io_mem_dataAddr doubles as the walking address register: it is only
   // loaded on entry to REQ, so it holds its last value everywhere else.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= S_IDLE;
         remaining       <= '0;
         lat_cnt         <= '0;
         io_mem_dataAddr <= '0;
         io_out_valid    <= 1'b0;
         io_out_bits     <= '0;
         io_out_last     <= 1'b0;
         io_done         <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum            <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (io_start) begin
                  remaining <= io_wordCount;
                  lat_cnt   <= '0;
`ifdef DUMP_CHECKSUM_EN
                  csum      <= '0;
`endif
                  if (io_wordCount == 32'd0) begin
                     state <= S_DONE;
                  end else begin
                     io_mem_dataAddr <= io_baseAddr & ~64'd3;
                     state           <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (lat_cnt == LAT_MAX) begin
                  io_out_bits  <= io_mem_lsuData;
                  io_out_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                  io_out_last  <= 1'b0;
                  csum         <= csum + io_mem_lsuData;
`else
                  io_out_last  <= (remaining == 32'd1);
`endif
                  state        <= S_HOLD;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            S_HOLD: begin
               if (io_out_ready) begin
                  io_out_valid <= 1'b0;
                  io_out_last  <= 1'b0;
                  if (remaining > 32'd1) begin
                     remaining       <= remaining - 32'd1;
                     io_mem_dataAddr <= io_mem_dataAddr + 64'd4;
                     lat_cnt         <= '0;
                     state           <= S_REQ;
                  end else begin
`ifdef DUMP_CHECKSUM_EN
                     io_out_bits  <= csum;
                     io_out_valid <= 1'b1;
                     io_out_last  <= 1'b1;
                     state        <= S_CSUM;
`else
                     io_done <= 1'b1;
                     state   <= S_DONE;
`endif
                  end
               end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
               if (io_out_ready) begin
                  io_out_valid <= 1'b0;
                  io_out_last  <= 1'b0;
                  io_done      <= 1'b1;
                  state        <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               // Entry from a handshake arrives with io_done already set.
               // The zero-count path arrives with it clear and spends one
               // extra cycle here to raise it.
               if (io_done) begin
                  io_done <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  io_done <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// tb_mem_dump_streamer
//   Two instances (RD_LAT=0 and RD_LAT=2) share a clock and reset, and each one
//   is attached to a memory model. Expected words are queued when a dump is
//   started and are popped when the sink sees a handshake.
//   Honours DUMP_CHECKSUM_EN the same way the design does.
module tb_mem_dump_streamer;

`ifdef DUMP_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        timed;
      logic [31:0] off;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        start [2];
   logic [63:0] base  [2];
   logic [31:0] cnt   [2];
   logic        ready [2];
   logic [63:0] addr  [2];
   logic        wen   [2];
   logic [31:0] wdata [2];
   logic [2:0]  f3    [2];
   logic [31:0] lsu   [2];
   logic        valid [2];
   logic [31:0] bits  [2];
   logic        last  [2];
   logic        busy  [2];
   logic        done  [2];

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   int unsigned start_cyc = 0;
   logic        saw_valid [2];
   exp_t        expq [$];

   mem_dump_streamer #(.RD_LAT(0)) u0 (
      .clock(clock), .reset(reset), .io_start(start[0]), .io_baseAddr(base[0]),
      .io_wordCount(cnt[0]), .io_mem_dataAddr(addr[0]), .io_mem_writeEn(wen[0]),
      .io_mem_writeData(wdata[0]), .io_mem_func3(f3[0]), .io_mem_lsuData(lsu[0]),
      .io_out_valid(valid[0]), .io_out_ready(ready[0]), .io_out_bits(bits[0]),
      .io_out_last(last[0]), .io_busy(busy[0]), .io_done(done[0])
   );

   mem_dump_streamer #(.RD_LAT(2)) u2 (
      .clock(clock), .reset(reset), .io_start(start[1]), .io_baseAddr(base[1]),
      .io_wordCount(cnt[1]), .io_mem_dataAddr(addr[1]), .io_mem_writeEn(wen[1]),
      .io_mem_writeData(wdata[1]), .io_mem_func3(f3[1]), .io_mem_lsuData(lsu[1]),
      .io_out_valid(valid[1]), .io_out_ready(ready[1]), .io_out_bits(bits[1]),
      .io_out_last(last[1]), .io_busy(busy[1]), .io_done(done[1])
   );

   // Memory contents: 0x80..0x8C hold 0x11,0x22,0x33,0x44; everything else is
   // derived from the address so that a wrong address shows up as wrong data.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a >= 64'h80 && a <= 64'h8C)
         return 32'h11 * {30'd0, a[3:2]} + 32'h11;
      return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
   endfunction

   function automatic int unsigned lat(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic int unsigned done_off(input int d, input int unsigned n);
      if (n == 0) return 2;
      return (lat(d) + 2) * n + (CSUM ? 2 : 1);
   endfunction

   logic [63:0] p1, p2;
   always @(posedge clock) begin
      p1 <= addr[1];
      p2 <= p1;
   end
   assign lsu[0] = mem_word(addr[0]);
   assign lsu[1] = mem_word(p2);

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Sink side: sampled mid-cycle, away from the active edge.
   always @(negedge clock) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (valid[d]) saw_valid[d] = 1'b1;
         if (valid[d] && ready[d]) begin
            if (expq.size() == 0) begin
               check_eq("extra_word", 1, 0);
            end else begin
               e = expq.pop_front();
               check_eq("word_bits", bits[d], e.data);
               check_eq("word_last", last[d], e.last);
               if (e.timed)
                  check_eq("word_time", 64'(cyc - start_cyc), 64'(e.off));
            end
         end
      end
   end

   task automatic start_dump(input int d, input logic [63:0] b, input logic [31:0] n,
                             input logic timed);
      logic [63:0] a;
      logic [31:0] sum;
      exp_t        e;
      a   = b & ~64'd3;
      sum = '0;
      for (int unsigned i = 0; i < n; i++) begin
         e.data  = mem_word(a);
         e.last  = (i == n - 1) && !CSUM;
         e.timed = timed;
         e.off   = (lat(d) + 2) * (i + 1);
         sum     = sum + e.data;
         expq.push_back(e);
         a       = a + 64'd4;
      end
      if (CSUM && n != 0) begin
         e.data  = sum;
         e.last  = 1'b1;
         e.timed = timed;
         e.off   = (lat(d) + 2) * n + 1;
         expq.push_back(e);
      end
      saw_valid[d] = 1'b0;
      start_cyc    = cyc;
      base[d]      = b;
      cnt[d]       = n;
      start[d]     = 1'b1;
      step();
      start[d]     = 1'b0;
      check_eq("busy_after_start", busy[d], 1);
   endtask

   task automatic wait_valid(input int d);
      int unsigned n;
      n = 0;
      while (!valid[d] && n < 100) begin
         step();
         n++;
      end
      check_eq("valid_seen", valid[d], 1);
   endtask

   task automatic wait_done(input int d, input int exp_off);
      int unsigned n;
      n = 0;
      while (!done[d] && n < 300) begin
         step();
         n++;
      end
      check_eq("done_seen", done[d], 1);
      if (exp_off >= 0)
         check_eq("done_time", 64'(cyc - start_cyc), 64'(exp_off));
      step();
      check_eq("done_pulse", done[d], 0);
      check_eq("busy_idle", busy[d], 0);
      check_eq("sb_empty", 64'(expq.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] hold_bits;
      logic [63:0] hold_addr;
      logic        stable;
      logic        got_done;

      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0; base[d] = '0; cnt[d] = '0; ready[d] = 1'b1; saw_valid[d] = 1'b0;
      end
      step();
      step();
      reset = 1'b0;

      for (int d = 0; d < 2; d++) begin
         check_eq("rst_addr",  addr[d], 0);
         check_eq("rst_valid", valid[d], 0);
         check_eq("rst_bits",  bits[d], 0);
         check_eq("rst_last",  last[d], 0);
         check_eq("rst_busy",  busy[d], 0);
         check_eq("rst_done",  done[d], 0);
         check_eq("wen",       wen[d], 0);
         check_eq("wdata",     wdata[d], 0);
         check_eq("func3",     f3[d], 3'b010);
      end
      step();

      // Basic stream, RD_LAT=0, ready held high.
      start_dump(0, 64'h80, 4, 1'b1);
      wait_done(0, done_off(0, 4));
      check_eq("basic_addr_hold", addr[0], 64'h8C);

      // Zero count: done only, no valid, address untouched.
      start_dump(0, 64'h500, 0, 1'b1);
      wait_done(0, done_off(0, 0));
      check_eq("zero_no_valid", saw_valid[0], 0);
      check_eq("zero_addr", addr[0], 64'h8C);

      // Unaligned base with RD_LAT=2.
      start_dump(1, 64'h103, 2, 1'b1);
      wait_done(1, done_off(1, 2));
      check_eq("unalign_addr", addr[1], 64'h104);

      // Address wrap past the top of the space.
      start_dump(0, 64'hFFFF_FFFF_FFFF_FFFC, 2, 1'b1);
      wait_done(0, done_off(0, 2));
      check_eq("wrap_addr", addr[0], 64'h0);

      // Backpressure stall of 10 cycles; a start during the stall is ignored.
      ready[0] = 1'b0;
      start_dump(0, 64'h200, 3, 1'b0);
      wait_valid(0);
      hold_bits = bits[0];
      hold_addr = addr[0];
      stable    = 1'b1;
      for (int unsigned i = 0; i < 10; i++) begin
         start[0] = (i == 3);
         base[0]  = 64'h300;
         cnt[0]   = 32'd5;
         step();
         if (!valid[0] || bits[0] !== hold_bits || addr[0] !== hold_addr || last[0] !== 1'b0)
            stable = 1'b0;
      end
      start[0] = 1'b0;
      check_eq("stall_stable", stable, 1);
      check_eq("stall_bits", bits[0], mem_word(64'h200));
      check_eq("stall_addr", addr[0], 64'h200);
      ready[0] = 1'b1;
      wait_done(0, -1);
      check_eq("stall_end_addr", addr[0], 64'h208);

      // Reset while word 2 is held, then a fresh dump.
      ready[0] = 1'b0;
      start_dump(0, 64'h80, 4, 1'b0);
      wait_valid(0);
      ready[0] = 1'b1;
      step();
      ready[0] = 1'b0;
      wait_valid(0);
      check_eq("abort_word2", bits[0], 32'h22);
      reset = 1'b1;
      step();
      reset = 1'b0;
      expq.delete();
      check_eq("abort_valid", valid[0], 0);
      check_eq("abort_busy",  busy[0], 0);
      check_eq("abort_bits",  bits[0], 0);
      check_eq("abort_addr",  addr[0], 0);
      got_done = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (done[0]) got_done = 1'b1;
         step();
      end
      check_eq("abort_no_done", got_done, 0);
      ready[0] = 1'b1;
      start_dump(0, 64'h84, 2, 1'b1);
      wait_done(0, done_off(0, 2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
